// File: rtl/cp0_except_commit.sv
// ---------------------------------------------------------------------------
// cp0_except_commit : CP0 register file, exception/ERET commit and redirect
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cp0_except_commit #(
  parameter logic [31:0] EXC_VEC     = 32'hBFC00380,
  parameter logic [31:0] REFILL_VEC  = 32'hBFC00200,
  parameter logic [31:0] COMPARE_RST = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delay_slot_i,
  input  logic [31:0] bad_addr_i,
  input  logic        mem_store_i,
  input  logic [5:0]  int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] cp0_status_o,
  output logic [31:0] cp0_cause_o,
  output logic [31:0] cp0_epc_o,
  output logic [31:0] newpc_o,
  output logic        flush_o,
  output logic        timer_int_o
);

  localparam logic [31:0] STATUS_RST   = 32'h00400000;
  localparam logic [31:0] STATUS_WMASK = 32'h0040FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h00000300;
  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;

  logic [4:0]  exc_code;
  logic        is_refill;
  logic        load_bad;
  logic        set_ce;
  logic        is_eret;
  logic        is_exc;
  logic        cmp_wr;
  logic        ti_next;

  always_comb begin
    exc_code  = 5'd10;
    is_refill = 1'b0;
    load_bad  = 1'b0;
    set_ce    = 1'b0;
    case (excepttype_i)
      32'h01: exc_code = 5'd0;
      32'h04: begin exc_code = 5'd4; load_bad = 1'b1; end
      32'h05: begin exc_code = 5'd5; load_bad = 1'b1; end
      32'h08, 32'h09, 32'h0a, 32'h0c, 32'h0d: exc_code = excepttype_i[4:0];
      32'h0b: begin exc_code = 5'd11; set_ce = 1'b1; end
      32'h10: begin exc_code = 5'd2; is_refill = 1'b1; load_bad = 1'b1; end
      32'h11: begin exc_code = 5'd2; load_bad = 1'b1; end
      32'h12: begin
        exc_code  = mem_store_i ? 5'd3 : 5'd2;
        is_refill = 1'b1;
        load_bad  = 1'b1;
      end
      32'h13: begin exc_code = mem_store_i ? 5'd3 : 5'd2; load_bad = 1'b1; end
      32'h14: begin exc_code = 5'd1; load_bad = 1'b1; end
      default: ;
    endcase
  end

  assign is_eret = (excepttype_i == 32'h0000000e);
  assign is_exc  = (excepttype_i != 32'h0) && !is_eret;
  assign flush_o = !rst && (excepttype_i != 32'h0);

  // Refill only uses its own vector while not already inside an exception handler.
  assign newpc_o = is_eret                   ? epc_q      :
                   (is_refill && !status_q[1]) ? REFILL_VEC : EXC_VEC;

  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    count_d    = tick_q ? count_q + 32'd1 : count_q;
    tick_d     = !tick_q;
    cmp_wr     = 1'b0;

    if (is_exc) begin
      if (!status_q[1]) begin
        epc_d       = in_delay_slot_i ? pc_i - 32'd4 : pc_i;
        cause_d[31] = in_delay_slot_i;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = exc_code;
      if (set_ce)   cause_d[29:28] = 2'b01;
      if (load_bad) badvaddr_d     = bad_addr_i;
    end else if (is_eret) begin
      status_d[1] = 1'b0;
    end else if (we_i) begin
      case (waddr_i)
        REG_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
        REG_CAUSE:   cause_d  = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
        REG_EPC:     epc_d    = wdata_i;
        REG_COUNT:   count_d  = wdata_i;
        REG_COMPARE: begin compare_d = wdata_i; cmp_wr = 1'b1; end
        default: ;
      endcase
    end

    // A Compare write beats a coincident match, so TI ends up cleared.
    ti_next = cmp_wr ? 1'b0
                     : (cause_q[30] | ((count_q == compare_q) && (compare_q != 32'h0)));
    cause_d[30]    = ti_next;
    cause_d[15:10] = {int_i[5] | ti_next, int_i[4:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      cause_q    <= 32'h0;
      epc_q      <= 32'h0;
      badvaddr_q <= 32'h0;
      count_q    <= 32'h0;
      compare_q  <= COMPARE_RST;
      tick_q     <= 1'b0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    rdata_o = 32'h0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr_q;
      REG_COUNT:    rdata_o = count_q;
      REG_COMPARE:  rdata_o = compare_q;
      REG_STATUS:   rdata_o = status_q;
      REG_CAUSE:    rdata_o = cause_q;
      REG_EPC:      rdata_o = epc_q;
      default: ;
    endcase
  end

  assign cp0_status_o = status_q;
  assign cp0_cause_o  = cause_q;
  assign cp0_epc_o    = epc_q;
  assign timer_int_o  = cause_q[30];

endmodule

`default_nettype wire

// File: tb/tb_cp0_except_commit.sv
// ---------------------------------------------------------------------------
// tb_cp0_except_commit : directed + randomized bench with reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_cp0_except_commit;

  localparam logic [31:0] C_EXC = 32'hBFC00380;
  localparam logic [31:0] C_REF = 32'hBFC00200;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] et, pc, bad, wd;
  logic        ds, st, we;
  logic [5:0]  intr;
  logic [4:0]  wa, ra;
  logic [31:0] rdata, status, cause, epc, newpc;
  logic        flush, tint;

  int total = 0;
  int bad_n = 0;

  logic [31:0] m_status, m_cause, m_epc, m_bva, m_count, m_compare;
  logic        m_tick;

  cp0_except_commit dut (
    .clk(clk), .rst(rst), .excepttype_i(et), .pc_i(pc), .in_delay_slot_i(ds),
    .bad_addr_i(bad), .mem_store_i(st), .int_i(intr), .we_i(we), .waddr_i(wa),
    .wdata_i(wd), .raddr_i(ra), .rdata_o(rdata), .cp0_status_o(status),
    .cp0_cause_o(cause), .cp0_epc_o(epc), .newpc_o(newpc), .flush_o(flush),
    .timer_int_o(tint)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    case (a)
      5'd8:    return m_bva;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic idle();
    et = 0; we = 0; wa = 0; wd = 0; ds = 0; st = 0; intr = 0; bad = 0;
  endtask

  // One clock: check combinational outputs against the model, advance the model, check registers.
  task automatic step();
    logic [4:0]  code;
    logic        refill, ld, eret, exc, ti, cw;
    logic [31:0] s, c, e, b, cn, cp, exp_pc;
    eret   = (et == 32'h0e);
    exc    = (et != 0) && !eret;
    refill = (et == 32'h10) || (et == 32'h12);
    ld     = (et == 32'h04) || (et == 32'h05) || (et >= 32'h10 && et <= 32'h14);
    case (et)
      32'h01: code = 0;
      32'h04: code = 4;
      32'h05: code = 5;
      32'h08: code = 8;
      32'h09: code = 9;
      32'h0a: code = 10;
      32'h0b: code = 11;
      32'h0c: code = 12;
      32'h0d: code = 13;
      32'h10, 32'h11: code = 2;
      32'h12, 32'h13: code = st ? 5'd3 : 5'd2;
      32'h14: code = 1;
      default: code = 10;
    endcase
    #1;
    chk("flush", {31'd0, flush}, (!rst && et != 0) ? 32'd1 : 32'd0);
    if (!rst && et != 0) begin
      if (eret) exp_pc = m_epc;
      else if (refill && !m_status[1]) exp_pc = C_REF;
      else exp_pc = C_EXC;
      chk("newpc", newpc, exp_pc);
    end
    chk("rdata", rdata, mread(ra));

    s = m_status; c = m_cause; e = m_epc; b = m_bva; cp = m_compare;
    cn = m_count + (m_tick ? 32'd1 : 32'd0);
    cw = 0;
    if (exc) begin
      if (!m_status[1]) begin
        e = ds ? pc - 4 : pc;
        c[31] = ds;
      end
      s[1] = 1;
      c[6:2] = code;
      if (et == 32'h0b) c[29:28] = 2'b01;
      if (ld) b = bad;
    end else if (eret) begin
      s[1] = 0;
    end else if (we) begin
      if (wa == 12) s = (m_status & ~32'h0040FF03) | (wd & 32'h0040FF03);
      if (wa == 13) c = (m_cause & ~32'h00000300) | (wd & 32'h00000300);
      if (wa == 14) e = wd;
      if (wa == 9)  cn = wd;
      if (wa == 11) begin cp = wd; cw = 1; end
    end
    if (cw) ti = 0;
    else if (m_count == m_compare && m_compare != 0) ti = 1;
    else ti = m_cause[30];
    c[30] = ti;
    c[15:10] = {intr[5] | ti, intr[4:0]};

    @(posedge clk);
    if (rst) begin
      m_status = 32'h00400000; m_cause = 0; m_epc = 0; m_bva = 0;
      m_count = 0; m_compare = 0; m_tick = 0;
    end else begin
      m_status = s; m_cause = c; m_epc = e; m_bva = b;
      m_count = cn; m_compare = cp; m_tick = !m_tick;
    end
    #1;
    chk("status", status, m_status);
    chk("cause", cause, m_cause);
    chk("epc", epc, m_epc);
    chk("timer", {31'd0, tint}, {31'd0, m_cause[30]});
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    ra = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  logic [31:0] codes [16];
  logic [4:0]  wregs [7];

  initial begin
    idle(); pc = 0; ra = 0; rst = 1;
    @(posedge clk); #1;
    m_status = 32'h00400000; m_cause = 0; m_epc = 0; m_bva = 0;
    m_count = 0; m_compare = 0; m_tick = 0;

    // reset state; flush suppressed while rst is high
    et = 32'h08;
    step();
    idle();
    rd("rst_status", 12, 32'h00400000);
    rd("rst_cause", 13, 0);
    rd("rst_epc", 14, 0);
    rd("rst_count", 9, 0);
    rd("rst_compare", 11, 0);
    rst = 0;

    // syscall-style exception
    et = 32'h08; pc = 32'hBFC00100; ds = 0;
    #1;
    chk("exc08_flush", {31'd0, flush}, 32'd1);
    chk("exc08_newpc", newpc, 32'hBFC00380);
    step(); idle();
    chk("exc08_epc", epc, 32'hBFC00100);
    chk("exc08_code", {27'd0, cause[6:2]}, 32'd8);
    chk("exc08_exl", {31'd0, status[1]}, 32'd1);
    et = 32'h0e; step(); idle();

    // AdEL in a delay slot, then ERET back to the branch
    et = 32'h04; pc = 32'hBFC00204; ds = 1; bad = 32'h3;
    step(); idle();
    chk("adel_epc", epc, 32'hBFC00200);
    chk("adel_bd", {31'd0, cause[31]}, 32'd1);
    rd("adel_bva", 8, 32'h3);
    et = 32'h0e;
    #1;
    chk("eret_newpc", newpc, 32'hBFC00200);
    step(); idle();
    chk("eret_exl", {31'd0, status[1]}, 32'd0);

    // TLB refill on store, EXL=0 then EXL=1
    et = 32'h12; st = 1; pc = 32'h80001000; bad = 32'h12345678;
    #1;
    chk("refill0_newpc", newpc, 32'hBFC00200);
    step(); idle();
    chk("refill0_code", {27'd0, cause[6:2]}, 32'd3);
    et = 32'h12; st = 1; pc = 32'h80002000;
    #1;
    chk("refill1_newpc", newpc, 32'hBFC00380);
    step(); idle();
    chk("refill1_epc", epc, 32'h80001000);
    et = 32'h0e; step(); idle();

    // timer
    we = 1; wa = 11; wd = 5; step();
    we = 1; wa = 9;  wd = 0; step(); idle();
    begin
      int n = 0;
      while (!tint && n < 40) begin step(); n++; end
    end
    chk("ti_set", {31'd0, tint}, 32'd1);
    chk("ti_ip7", {31'd0, cause[15]}, 32'd1);
    we = 1; wa = 11; wd = 100; step(); idle();
    chk("ti_clr", {31'd0, tint}, 32'd0);

    // MTC0 Status dropped under an exception, then applied alone
    we = 1; wa = 12; wd = 32'hFFFFFFFF; et = 32'h09;
    step(); idle();
    chk("mtc0_drop", status, 32'h00400002);
    we = 1; wa = 12; wd = 32'hFFFFFFFF;
    step(); idle();
    chk("mtc0_status", status, 32'h0040FF03);

    // randomized traffic against the model
    codes = '{32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0a, 32'h0b, 32'h0c,
              32'h0d, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h0e, 32'h100};
    wregs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) < 7) et = 0;
      else begin
        et = codes[$urandom_range(0, 15)];
        if (et == 32'h100) et = $urandom | 32'h100;
      end
      pc   = $urandom & 32'hFFFFFFFC;
      ds   = $urandom_range(0, 1);
      bad  = $urandom;
      st   = $urandom_range(0, 1);
      intr = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      we   = ($urandom_range(0, 2) == 0);
      wa   = wregs[$urandom_range(0, 6)];
      wd   = $urandom_range(0, 1) ? 32'($urandom_range(0, 30)) : $urandom;
      ra   = ($urandom_range(0, 7) == 0) ? 5'd0 : wregs[$urandom_range(0, 6)];
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cp0_except_commit.md
Name: cp0_except_commit

Overview:
- Consumer side of the exception-type encoding produced by the memory-stage exception prioritiser.
- Holds the CP0 architectural registers: Status, Cause, EPC, BadVAddr, Count, Compare.
- Decodes the incoming 32-bit exception type and commits the exception (or ERET) to those registers.
- Returns the redirect PC and a pipeline flush.
- Feeds Status and Cause back to the prioritiser so it can evaluate interrupts.

Parameters:
- EXC_VEC, 32'hBFC00380, general exception vector.
- REFILL_VEC, 32'hBFC00200, TLB refill vector. Used only when Status.EXL=0.
- COMPARE_RST, 32'h00000000, reset value of Compare.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- excepttype_i  in  32  encoded exception from the prioritiser; 0 = none.
- pc_i  in  32  PC of the excepting instruction.
- in_delay_slot_i  in  1  excepting instruction is in a branch delay slot.
- bad_addr_i  in  32  faulting virtual address (fetch or data).
- mem_store_i  in  1  data-side TLB fault came from a store.
- int_i  in  6  hardware interrupt lines, level-sensitive.
- we_i  in  1  MTC0 write enable.
- waddr_i  in  5  MTC0 register number (sel 0 only).
- wdata_i  in  32  MTC0 data.
- raddr_i  in  5  MFC0 register number.
- rdata_o  out  32  MFC0 data, combinational; 0 for unimplemented registers.
- cp0_status_o  out  32  Status (reg 12).
- cp0_cause_o  out  32  Cause (reg 13).
- cp0_epc_o  out  32  EPC (reg 14).
- newpc_o  out  32  redirect target, valid when flush_o=1.
- flush_o  out  1  pipeline flush/redirect.
- timer_int_o  out  1  Cause.TI.

Behaviour:
- Reset (rst=1 at clk edge):
  - Status=32'h00400000 (BEV=1), Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=COMPARE_RST, internal tick=0.
  - Outputs follow registers; flush_o=0 during reset regardless of excepttype_i.
- flush_o / newpc_o: combinational, same cycle as excepttype_i!=0. Register effects land at the next clk edge.
- Decode map: excepttype → ExcCode, newpc:
  - 0x01 → 0, EXC_VEC.
  - 0x04 → 4 (AdEL), EXC_VEC, BadVAddr loaded.
  - 0x05 → 5 (AdES), EXC_VEC, BadVAddr loaded.
  - 0x08 → 8, EXC_VEC.
  - 0x09 → 9, EXC_VEC.
  - 0x0a → 10, EXC_VEC.
  - 0x0b → 11, EXC_VEC; Cause.CE=2'b01.
  - 0x0c → 12, EXC_VEC.
  - 0x0d → 13, EXC_VEC.
  - 0x10 → 2, refill vector.
  - 0x11 → 2, EXC_VEC.
  - 0x12 → (mem_store_i?3:2), refill vector.
  - 0x13 → (mem_store_i?3:2), EXC_VEC.
  - 0x14 → 1, EXC_VEC.
  - 0x10–0x14 all load BadVAddr.
  - Refill vector = REFILL_VEC if Status.EXL=0, else EXC_VEC.
  - Any other nonzero code except 0x0e: flush_o=1, newpc=EXC_VEC, ExcCode=10.
- Exception entry at the edge:
  - If Status.EXL=0: EPC = in_delay_slot_i ? pc_i-4 : pc_i, and Cause.BD = in_delay_slot_i.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Status.EXL=1; Cause[6:2]=ExcCode.
- ERET (0x0e): newpc_o=EPC (the pre-edge value); Status.EXL cleared at the edge; no other register changes.
- Priority at one edge: reset > exception/ERET > MTC0. An MTC0 coinciding with excepttype_i!=0 is dropped.
- MTC0 write masks:
  - Status: 32'h0040FF03 (BEV, IM, EXL, IE).
  - Cause: 32'h00000300 (IP1:0).
  - EPC, BadVAddr: BadVAddr is read-only, write ignored; EPC fully writable.
  - Count, Compare: full 32 bits.
  - Write to Compare clears Cause.TI.
- Count:
  - The internal tick toggles every cycle; Count += 1 on cycles where tick=1, i.e. at half clock rate, wrapping at 2^32.
  - An MTC0 to Count loads wdata_i and wins over the increment that edge.
- Timer:
  - When Count==Compare and Compare!=0, Cause.TI sets at the next edge.
  - TI is sticky until a Compare write; a Compare write and a match on the same edge leave TI=0.
- Cause.IP[7:2] is resampled every cycle as {int_i[5] | TI, int_i[4:0]}. IP[1:0] is software-written only.
- MFC0 read: a register with a write on the same edge returns the old value (no bypass).

Test Plan:
- Reset, then read regs 12/13/14/9/11 → 32'h00400000, 0, 0, Count=0, Compare=0; flush_o=0.
- excepttype_i=0x08, pc_i=32'hBFC00100, delay slot 0 → flush_o=1, newpc_o=32'hBFC00380 same cycle; next cycle EPC=32'hBFC00100, Cause[6:2]=8, Status.EXL=1.
- With EXL=0: excepttype_i=0x04, pc=32'hBFC00204, delay slot 1, bad_addr=32'h00000003 → EPC=32'hBFC00200, Cause.BD=1, BadVAddr=3. Then issue ERET → newpc_o=32'hBFC00200, EXL=0 next cycle.
- excepttype_i=0x12, mem_store_i=1, EXL=0 → newpc_o=32'hBFC00200, ExcCode=3. Repeat with EXL=1 → newpc_o=32'hBFC00380, EPC unchanged.
- MTC0 Compare=5, Count=0 → TI=1 after Count reaches 5 (≈10 cycles) and cp0_cause_o[15]=1. MTC0 Compare=100 → TI=0.
- MTC0 Status=32'hFFFFFFFF in the same cycle as excepttype_i=0x09 → Status=32'h00400002 (write dropped, EXL set). Alone → Status=32'h0040FF03.
